multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the immediate-format select consumed by the immediate generator mux, plus the register-file, PC and data-memory strobes. Sits between the instruction/data memory ports and the existing datapath (ALU, register file, immediate generator).

---
 rtl/multicycle_ctrl_if.sv | 22 ++
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Instruction-fetch and data-memory handshake bundle for multicycle_ctrl.
// master = the controller issuing requests, slave = the memory side.
interface multicycle_ctrl_if #(
    parameter int INSTRUCTION = 32
);
    logic                   instr_req;
    logic                   instr_valid;
    logic [INSTRUCTION-1:0] instruction;
    logic                   dmem_req;
    logic                   dmem_we;
    logic                   dmem_ack;

    modport master (
        output instr_req, dmem_req, dmem_we,
        input  instr_valid, instruction, dmem_ack
    );

    modport slave (
        input  instr_req, dmem_req, dmem_we,
        output instr_valid, instruction, dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB, with sticky TRAP.
// Define MULTICYCLE_CTRL_TIMEOUT_EN to bound FETCH/MEM waits by MEM_TIMEOUT cycles.
module multicycle_ctrl #(
    parameter int INSTRUCTION = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_if.master    bus,
    input  logic                 branch_taken,
    output logic [2:0]           imm_sel,
    output logic                 alu_src_imm,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 trap,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_JALR, C_STORE,
        C_BRANCH, C_JAL, C_LUI, C_AUIPC, C_ILL
    } cls_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [INSTRUCTION-1:0] r_ir;
    cls_t                   w_cls;
    logic [2:0]             w_imm_sel;
    logic                   w_alu_imm;
    logic                   w_wait;

    logic                   w_instr_req;
    logic                   w_dmem_req;
    logic                   w_dmem_we;

    always_comb begin
        w_cls     = C_ILL;
        w_imm_sel = 3'd0;
        w_alu_imm = 1'b0;
        case (r_ir[6:0])
            7'b0110011: begin w_cls = C_R;      w_imm_sel = 3'd0; w_alu_imm = 1'b0; end
            7'b0010011: begin w_cls = C_IALU;   w_imm_sel = 3'd1; w_alu_imm = 1'b1; end
            7'b0000011: begin w_cls = C_LOAD;   w_imm_sel = 3'd1; w_alu_imm = 1'b1; end
            7'b1100111: begin w_cls = C_JALR;   w_imm_sel = 3'd1; w_alu_imm = 1'b1; end
            7'b0100011: begin w_cls = C_STORE;  w_imm_sel = 3'd2; w_alu_imm = 1'b1; end
            7'b1100011: begin w_cls = C_BRANCH; w_imm_sel = 3'd3; w_alu_imm = 1'b0; end
            7'b1101111: begin w_cls = C_JAL;    w_imm_sel = 3'd4; w_alu_imm = 1'b0; end
            7'b0110111: begin w_cls = C_LUI;    w_imm_sel = 3'd5; w_alu_imm = 1'b1; end
            7'b0010111: begin w_cls = C_AUIPC;  w_imm_sel = 3'd5; w_alu_imm = 1'b1; end
            default:    begin w_cls = C_ILL;    w_imm_sel = 3'd0; w_alu_imm = 1'b0; end
        endcase
    end

    assign w_wait = ((r_state == S_FETCH) && !bus.instr_valid) ||
                    ((r_state == S_MEM)   && !bus.dmem_ack);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_timeout;
    assign w_timeout = w_wait && (r_wait_cnt == CNT_W'(MEM_TIMEOUT));
`else
    logic w_timeout;
    logic w_unused_cfg;
    assign w_timeout    = 1'b0;
    assign w_unused_cfg = (MEM_TIMEOUT != 0);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = bus.instr_valid ? S_DECODE : S_FETCH;
            S_DECODE: w_next = (w_cls == C_ILL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (w_cls == C_BRANCH)
                    w_next = S_FETCH;
                else if ((w_cls == C_LOAD) || (w_cls == C_STORE))
                    w_next = S_MEM;
                else
                    w_next = S_WB;
            end
            S_MEM: begin
                if (bus.dmem_ack)
                    w_next = (w_cls == C_LOAD) ? S_WB : S_FETCH;
                else
                    w_next = S_MEM;
            end
            S_WB:     w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
        // A handshake landing on the final counted cycle still takes priority.
        if (w_timeout)
            w_next = S_TRAP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && bus.instr_valid)
                r_ir <= bus.instruction;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
            if (w_wait && (w_next == r_state))
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
`endif
        end
    end

    // Strobes are decoded from state/IR; the EXEC branch and MEM store-ack
    // strobes also follow the live inputs so they land in the same cycle.
    always_comb begin
        w_instr_req = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        imm_sel     = 3'd0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 2'd0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        trap        = 1'b0;
        state_o     = 3'd0;
        if (!rst) begin
            state_o = r_state;
            if ((r_state == S_DECODE) || (r_state == S_EXEC) ||
                (r_state == S_MEM)    || (r_state == S_WB)) begin
                imm_sel     = w_imm_sel;
                alu_src_imm = w_alu_imm;
            end
            case (r_state)
                S_FETCH: w_instr_req = 1'b1;
                S_EXEC: begin
                    if (w_cls == C_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? 2'd1 : 2'd0;
                    end
                end
                S_MEM: begin
                    w_dmem_req = 1'b1;
                    w_dmem_we  = (w_cls == C_STORE);
                    if ((w_cls == C_STORE) && bus.dmem_ack)
                        pc_we = 1'b1;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    if (w_cls == C_LOAD)
                        wb_sel = 2'd1;
                    else if ((w_cls == C_JAL) || (w_cls == C_JALR))
                        wb_sel = 2'd2;
                    if (w_cls == C_JAL)
                        pc_sel = 2'd1;
                    else if (w_cls == C_JALR)
                        pc_sel = 2'd2;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.instr_req = w_instr_req;
    assign bus.dmem_req  = w_dmem_req;
    assign bus.dmem_we   = w_dmem_we;

    // Only the opcode field steers control; the rest of IR feeds the datapath.
    logic w_unused_ir;
    assign w_unused_ir = ^r_ir[INSTRUCTION-1:7];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: per-cycle expected output words, one line per check.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [2:0]  imm_sel;
    logic        alu_src_imm;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        trap;
    logic [2:0]  state_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.INSTRUCTION(32)) bus ();

    multicycle_ctrl #(.INSTRUCTION(32), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .branch_taken (branch_taken),
        .imm_sel      (imm_sel),
        .alu_src_imm  (alu_src_imm),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .trap         (trap),
        .state_o      (state_o)
    );

    // {state, instr_req, dmem_req, dmem_we, imm_sel, alu_src_imm, reg_we, wb_sel, pc_we, pc_sel, trap}
    logic [16:0] obs;
    assign obs = {state_o, bus.instr_req, bus.dmem_req, bus.dmem_we, imm_sel, alu_src_imm,
                  reg_we, wb_sel, pc_we, pc_sel, trap};

    function automatic logic [16:0] ev(input logic [2:0] st, input logic ireq, input logic dreq,
                                       input logic dwe, input logic [2:0] isel, input logic asrc,
                                       input logic rwe, input logic [1:0] wsel, input logic pwe,
                                       input logic [1:0] psel, input logic trp);
        return {st, ireq, dreq, dwe, isel, asrc, rwe, wsel, pwe, psel, trp};
    endfunction

    localparam logic [31:0] G      = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI   = 32'h0050_0093;
    localparam logic [31:0] LUI    = 32'h0000_10B7;
    localparam logic [31:0] LW     = 32'h0000_2103;
    localparam logic [31:0] SW     = 32'h0010_2023;
    localparam logic [31:0] BEQ    = 32'h0000_0463;
    localparam logic [31:0] JAL    = 32'h0100_00EF;
    localparam logic [31:0] JALR   = 32'h0001_00E7;

    logic [16:0] EF, ET;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic a, input logic b);
        bus.instr_valid = v;
        bus.instruction = w;
        bus.dmem_ack    = a;
        branch_taken    = b;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, ADDI, 1'b1, 1'b1);
        tick();
        tick();
        n_total++;
        if (obs !== 17'd0) $display("FAIL reset_outputs obs=%h exp=%h", obs, 17'd0);
        else n_pass++;
        rst = 1'b0;
        drive(1'b0, G, 1'b0, 1'b0);
        n_total++;
        if (obs !== EF) $display("FAIL reset_fetch obs=%h exp=%h", obs, EF);
        else n_pass++;
        $display("reset: obs=%h", obs);
        tick();
    endtask

    task automatic test_alu();
        logic [31:0] w [10];
        logic [2:0]  s [10];
        logic [16:0] e [10];
        w = '{ADDI, G, G, G, G, LUI, G, G, G, G};
        s = '{3'b100, 3'b110, 3'b111, 3'b110, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        e = '{EF,
              ev(3'd1,0,0,0,3'd1,1,0,2'd0,0,2'd0,0),
              ev(3'd2,0,0,0,3'd1,1,0,2'd0,0,2'd0,0),
              ev(3'd4,0,0,0,3'd1,1,1,2'd0,1,2'd0,0),
              EF, EF,
              ev(3'd1,0,0,0,3'd5,1,0,2'd0,0,2'd0,0),
              ev(3'd2,0,0,0,3'd5,1,0,2'd0,0,2'd0,0),
              ev(3'd4,0,0,0,3'd5,1,1,2'd0,1,2'd0,0),
              EF};
        for (int i = 0; i < 10; i++) begin
            drive(s[i][2], w[i], s[i][1], s[i][0]);
            n_total++;
            if (obs !== e[i]) $display("FAIL alu cyc%0d obs=%h exp=%h", i, obs, e[i]);
            else n_pass++;
            $display("alu cyc%0d state=%0d obs=%h", i, state_o, obs);
            tick();
        end
    endtask

    task automatic test_load();
        logic [31:0] w [13];
        logic [2:0]  s [13];
        logic [16:0] e [13];
        logic [16:0] ld, le, lm, lw_wb;
        ld    = ev(3'd1,0,0,0,3'd1,1,0,2'd0,0,2'd0,0);
        le    = ev(3'd2,0,0,0,3'd1,1,0,2'd0,0,2'd0,0);
        lm    = ev(3'd3,0,1,0,3'd1,1,0,2'd0,0,2'd0,0);
        lw_wb = ev(3'd4,0,0,0,3'd1,1,1,2'd1,1,2'd0,0);
        w = '{LW, G, G, G, G, G, G, LW, G, G, G, G, G};
        s = '{3'b100, 3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b010,
              3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};
        e = '{EF, ld, le, lm, lm, lm, lw_wb, EF, ld, le, lm, lw_wb, EF};
        for (int i = 0; i < 13; i++) begin
            drive(s[i][2], w[i], s[i][1], s[i][0]);
            n_total++;
            if (obs !== e[i]) $display("FAIL load cyc%0d obs=%h exp=%h", i, obs, e[i]);
            else n_pass++;
            $display("load cyc%0d state=%0d obs=%h", i, state_o, obs);
            tick();
        end
    endtask

    task automatic test_store_branch();
        logic [31:0] w [12];
        logic [2:0]  s [12];
        logic [16:0] e [12];
        w = '{SW, G, G, G, G, BEQ, G, G, BEQ, G, G, G};
        s = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100,
              3'b000, 3'b001, 3'b100, 3'b001, 3'b000, 3'b000};
        e = '{EF,
              ev(3'd1,0,0,0,3'd2,1,0,2'd0,0,2'd0,0),
              ev(3'd2,0,0,0,3'd2,1,0,2'd0,0,2'd0,0),
              ev(3'd3,0,1,1,3'd2,1,0,2'd0,0,2'd0,0),
              ev(3'd3,0,1,1,3'd2,1,0,2'd0,1,2'd0,0),
              EF,
              ev(3'd1,0,0,0,3'd3,0,0,2'd0,0,2'd0,0),
              ev(3'd2,0,0,0,3'd3,0,0,2'd0,1,2'd1,0),
              EF,
              ev(3'd1,0,0,0,3'd3,0,0,2'd0,0,2'd0,0),
              ev(3'd2,0,0,0,3'd3,0,0,2'd0,1,2'd0,0),
              EF};
        for (int i = 0; i < 12; i++) begin
            drive(s[i][2], w[i], s[i][1], s[i][0]);
            n_total++;
            if (obs !== e[i]) $display("FAIL store_branch cyc%0d obs=%h exp=%h", i, obs, e[i]);
            else n_pass++;
            $display("store_branch cyc%0d state=%0d obs=%h", i, state_o, obs);
            tick();
        end
    endtask

    task automatic test_jump();
        logic [31:0] w [9];
        logic [2:0]  s [9];
        logic [16:0] e [9];
        w = '{JAL, G, G, G, JALR, G, G, G, G};
        s = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        e = '{EF,
              ev(3'd1,0,0,0,3'd4,0,0,2'd0,0,2'd0,0),
              ev(3'd2,0,0,0,3'd4,0,0,2'd0,0,2'd0,0),
              ev(3'd4,0,0,0,3'd4,0,1,2'd2,1,2'd1,0),
              EF,
              ev(3'd1,0,0,0,3'd1,1,0,2'd0,0,2'd0,0),
              ev(3'd2,0,0,0,3'd1,1,0,2'd0,0,2'd0,0),
              ev(3'd4,0,0,0,3'd1,1,1,2'd2,1,2'd2,0),
              EF};
        for (int i = 0; i < 9; i++) begin
            drive(s[i][2], w[i], s[i][1], s[i][0]);
            n_total++;
            if (obs !== e[i]) $display("FAIL jump cyc%0d obs=%h exp=%h", i, obs, e[i]);
            else n_pass++;
            $display("jump cyc%0d state=%0d obs=%h", i, state_o, obs);
            tick();
        end
    endtask

    task automatic test_trap();
        logic [16:0] e;
        for (int i = 0; i < 22; i++) begin
            if (i == 0) drive(1'b1, G, 1'b0, 1'b0);
            else        drive(i[0], G, i[0], ~i[0]);
            e = (i == 0) ? EF : (i == 1) ? ev(3'd1,0,0,0,3'd0,0,0,2'd0,0,2'd0,0) : ET;
            n_total++;
            if (obs !== e) $display("FAIL trap cyc%0d obs=%h exp=%h", i, obs, e);
            else n_pass++;
            $display("trap cyc%0d state=%0d obs=%h", i, state_o, obs);
            tick();
        end
        rst = 1'b1;
        drive(1'b0, G, 1'b0, 1'b0);
        n_total++;
        if (obs !== 17'd0) $display("FAIL trap_rst obs=%h exp=%h", obs, 17'd0);
        else n_pass++;
        tick();
        rst = 1'b0;
        drive(1'b0, G, 1'b0, 1'b0);
        n_total++;
        if (obs !== EF) $display("FAIL trap_clear obs=%h exp=%h", obs, EF);
        else n_pass++;
        $display("trap cleared: obs=%h", obs);
        tick();
    endtask

    task automatic test_rst_mid_mem();
        logic [31:0] wd [2];
        wd = '{LW, SW};
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, wd[k], 1'b0, 1'b0);
            tick();
            drive(1'b0, G, 1'b0, 1'b0);
            tick();
            tick();
            n_total++;
            if (state_o !== 3'd3) $display("FAIL rst_mem_enter%0d state=%0d exp=%0d", k, state_o, 3);
            else n_pass++;
            tick();
            rst = 1'b1;
            drive(1'b0, G, k[0], 1'b1);
            n_total++;
            if (obs !== 17'd0) $display("FAIL rst_mem%0d obs=%h exp=%h", k, obs, 17'd0);
            else n_pass++;
            tick();
            rst = 1'b0;
            drive(1'b0, G, 1'b0, 1'b0);
            n_total++;
            if (obs !== EF) $display("FAIL rst_mem_fetch%0d obs=%h exp=%h", k, obs, EF);
            else n_pass++;
            $display("rst_mid_mem%0d: obs=%h", k, obs);
            tick();
        end
    endtask

    task automatic test_wait();
        rst = 1'b1;
        drive(1'b0, G, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, G, 1'b1, 1'b0);
            n_total++;
            if (obs !== ((i < 16) ? EF : ET))
                $display("FAIL timeout cyc%0d obs=%h exp=%h", i, obs, (i < 16) ? EF : ET);
            else n_pass++;
            $display("timeout cyc%0d state=%0d", i, state_o);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
`else
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, G, 1'b1, 1'b0);
            n_total++;
            if (obs !== EF) $display("FAIL unbounded_wait cyc%0d obs=%h exp=%h", i, obs, EF);
            else n_pass++;
            tick();
        end
        $display("unbounded wait: state=%0d after 40 cycles", state_o);
`endif
    endtask

    initial begin
        EF = ev(3'd0,1,0,0,3'd0,0,0,2'd0,0,2'd0,0);
        ET = ev(3'd5,0,0,0,3'd0,0,0,2'd0,0,2'd0,1);
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.dmem_ack    = 1'b0;
        branch_taken    = 1'b0;
        test_reset();
        test_alu();
        test_load();
        test_store_branch();
        test_jump();
        test_trap();
        test_rst_mid_mem();
        test_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
